// File: rtl/adder_accumulator_ctrl.sv
// rtl/adder_accumulator_ctrl.sv - operand/accumulator control stage around a ripple adder
// Optional subtract mode selected by defining SUBTRACT_EN (adds the Sub input).
module adder_accumulator_ctrl #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
`ifdef SUBTRACT_EN
  input  logic             Sub,
`endif
  input  logic [WIDTH-1:0] SW,
  input  logic [WIDTH-1:0] S,
  input  logic             c_out,
  output logic [WIDTH-1:0] A_op,
  output logic [WIDTH-1:0] B_op,
  output logic             c_in,
  output logic             Carry,
  output logic             Busy,
  output logic             Done
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETTLE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE  = 2'd2;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic             run_prev_q, run_prev_d;
  logic             run_rise;
`ifdef SUBTRACT_EN
  logic             sub_q, sub_d;
`endif

  assign run_rise = Run & ~run_prev_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    done_d     = 1'b0;
    run_prev_d = Run;
`ifdef SUBTRACT_EN
    sub_d      = sub_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Clear/load has priority over a simultaneous press; that press is consumed.
        if (ClearA_LoadB) begin
          a_d     = '0;
          b_d     = SW;
          carry_d = 1'b0;
        end else if (run_rise) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_LOAD;
`ifdef SUBTRACT_EN
          sub_d   = Sub;
`endif
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        a_d     = S;
        carry_d = c_out;
        done_d  = 1'b1;
        state_d = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (!Run) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // run_prev resets high so a button held through reset is not seen as a press.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      done_q     <= 1'b0;
      run_prev_q <= 1'b1;
`ifdef SUBTRACT_EN
      sub_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      done_q     <= done_d;
      run_prev_q <= run_prev_d;
`ifdef SUBTRACT_EN
      sub_q      <= sub_d;
`endif
    end
  end

  assign A_op  = a_q;
  assign Carry = carry_q;
  assign Done  = done_q;
  assign Busy  = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
`ifdef SUBTRACT_EN
  assign B_op  = sub_q ? ~b_q : b_q;
  assign c_in  = sub_q;
`else
  assign B_op  = b_q;
  assign c_in  = 1'b0;
`endif

endmodule

// File: tb/tb_adder_accumulator_ctrl.sv
// tb/tb_adder_accumulator_ctrl.sv - self-checking bench for adder_accumulator_ctrl
module tb_adder_accumulator_ctrl;

  localparam int W      = 16;
  localparam int SETTLE = 2;

  logic         Clk = 1'b0;
  logic         Reset, Run, ClearA_LoadB, sub_in;
  logic [W-1:0] SW, S, A_op, B_op;
  logic         c_out, c_in, Carry, Busy, Done;

  adder_accumulator_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
`ifdef SUBTRACT_EN
    .Sub(sub_in),
`endif
    .SW(SW), .S(S), .c_out(c_out), .A_op(A_op), .B_op(B_op), .c_in(c_in),
    .Carry(Carry), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Behavioural stand-in for the ripple adder.
  assign {c_out, S} = {1'b0, A_op} + {1'b0, B_op} + {{W{1'b0}}, c_in};

  typedef struct { logic [W-1:0] a; logic c; } exp_t;
  typedef struct { logic [W-1:0] sw; int presses; logic [W-1:0] exp_a; logic exp_c; } vec_t;

  exp_t         sb[$];
  vec_t         vecs[6];
  logic [W-1:0] model_a, b_model;
  logic         model_c;
  int           n_vec = 0, n_fail = 0, done_cnt = 0, d0;

  always @(posedge Clk) if (Done) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] sw);
    @(negedge Clk); ClearA_LoadB = 1'b1; SW = sw;
    @(negedge Clk); ClearA_LoadB = 1'b0;
    model_a = '0; model_c = 1'b0; b_model = sw;
    check("load_a", A_op, 0);
    check("load_carry", Carry, 0);
    check("load_b", B_op, sw);
  endtask

  task automatic press(input logic sub);
    logic [W-1:0] bop;
    logic [W:0]   sum;
    exp_t         e;
    int           lat;
    bop = sub ? ~b_model : b_model;
    sum = {1'b0, model_a} + {1'b0, bop} + {{W{1'b0}}, sub};
    model_a = sum[W-1:0]; model_c = sum[W];
    sb.push_back('{model_a, model_c});
    @(negedge Clk); Run = 1'b1; sub_in = sub;
    lat = 0;
    do begin
      @(negedge Clk); lat++;
      if (lat == 1) sub_in = ~sub;  // Sub must already be latched
    end while (!Done && lat < 40);
    check("press_done", Done, 1);
    check("press_latency", lat, SETTLE + 2);
    e = sb.pop_front();
    check("press_a", A_op, e.a);
    check("press_carry", Carry, e.c);
    check("press_busy", Busy, 0);
    @(negedge Clk); Run = 1'b0;
    @(negedge Clk); sub_in = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h0005, 2, 16'h000A, 1'b0};
    vecs[1] = '{16'h8000, 2, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 2, 16'hFFFE, 1'b1};
    vecs[3] = '{16'h1234, 3, 16'h369C, 1'b0};
    vecs[4] = '{16'h0000, 1, 16'h0000, 1'b0};
    vecs[5] = '{16'h7FFF, 1, 16'h7FFF, 1'b0};

    Reset = 1'b1; Run = 1'b1; ClearA_LoadB = 1'b0; sub_in = 1'b0; SW = '0;
    model_a = '0; model_c = 1'b0; b_model = '0;
    repeat (3) @(negedge Clk);
    check("rst_a", A_op, 0);
    check("rst_b", B_op, 0);
    check("rst_carry", Carry, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    Reset = 1'b0;
    repeat (6) @(negedge Clk);
    check("held_run_busy", Busy, 0);
    check("held_run_done", done_cnt, 0);
    Run = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 6; i++) begin
      load(vecs[i].sw);
      d0 = done_cnt;
      for (int p = 0; p < vecs[i].presses; p++) press(1'b0);
      check($sformatf("vec%0d_a", i), A_op, vecs[i].exp_a);
      check($sformatf("vec%0d_carry", i), Carry, vecs[i].exp_c);
      check($sformatf("vec%0d_dones", i), done_cnt - d0, vecs[i].presses);
    end

    // Long hold: one add only; clear/load during SETTLE ignored.
    load(16'h0003);
    d0 = done_cnt;
    @(negedge Clk); Run = 1'b1;
    @(negedge Clk); ClearA_LoadB = 1'b1; SW = 16'hAAAA;
    @(negedge Clk); ClearA_LoadB = 1'b0; SW = 16'h0003;
    repeat (18) @(negedge Clk);
    check("hold_a", A_op, 16'h0003);
    check("hold_b", B_op, 16'h0003);
    check("hold_dones", done_cnt - d0, 1);
    Run = 1'b0;
    @(negedge Clk);

    // Clear/load and press in the same IDLE cycle: load wins, press consumed.
    d0 = done_cnt;
    @(negedge Clk); ClearA_LoadB = 1'b1; Run = 1'b1; SW = 16'h0042;
    @(negedge Clk); ClearA_LoadB = 1'b0;
    repeat (8) @(negedge Clk);
    check("tie_a", A_op, 0);
    check("tie_b", B_op, 16'h0042);
    check("tie_busy", Busy, 0);
    check("tie_dones", done_cnt - d0, 0);
    Run = 1'b0;
    model_a = '0; model_c = 1'b0; b_model = 16'h0042;
    press(1'b0);
    check("tie_after_a", A_op, 16'h0042);

    // Reset during SETTLE aborts the add.
    d0 = done_cnt;
    @(negedge Clk); Run = 1'b1;
    @(negedge Clk);
    check("abort_busy_pre", Busy, 1);
    Reset = 1'b1;
    #1;
    check("abort_a", A_op, 0);
    check("abort_busy", Busy, 0);
    @(negedge Clk); Reset = 1'b0;
    repeat (8) @(negedge Clk);
    check("abort_dones", done_cnt - d0, 0);
    check("abort_idle", Busy, 0);
    check("abort_a_hold", A_op, 0);
    Run = 1'b0;
    @(negedge Clk);

`ifdef SUBTRACT_EN
    load(16'h0005);
    press(1'b0);
    press(1'b1);
    check("sub_a0", A_op, 16'h0000);
    check("sub_c0", Carry, 1);
    press(1'b1);
    check("sub_a1", A_op, 16'hFFFB);
    check("sub_c1", Carry, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
